and_gate_bist: RTL and testbench
================================

// Module: and_gate_bist
//
// PURPOSE
//   Built-in self-test driver/checker for the registered and_gate cell.
//   - Drives and_gate's a/b inputs with an exhaustive pattern sequence.
//   - Samples its registered output y and checks each result against a&b.
//   - Reports a mismatch count, a per-pattern fail map and pass/done status.
//   - Sits beside the gate, sharing its clock and reset.
//
// PARAMETERS
//   NUM_PASSES  4  full sweeps of the 4 input patterns per run (>=1)
//   ERR_W       8  width of the saturating mismatch counter (>=1)
//
// PORTS
//   clk        in   1      single clock, rising edge
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      begin run; sampled in IDLE or DONE only
//   dut_a      out  1      drive to gate input a (registered)
//   dut_b      out  1      drive to gate input b (registered)
//   dut_y      in   1      gate registered output y
//   busy       out  1      high from the start edge until DONE is entered
//   done       out  1      run complete; held until next start or reset
//   pass       out  1      done & (err_count == 0)
//   err_count  out  ERR_W  mismatches this run; saturates at all-ones
//   fail_vec   out  4      bit i set if pattern i={a,b} mismatched at least once
//
// BEHAVIOUR
//   Reset:
//   - reset (async) forces all outputs to 0 and state to IDLE.
//   - This holds mid-run; no partial results are retained.
//   FSM states:
//   - IDLE: on start, go to DRIVE and load pattern 0.
//   - DRIVE: each cycle {dut_a,dut_b} = pat, pat = 0,1,2,3 repeating.
//     After 4*NUM_PASSES patterns, go to DRAIN with dut_a/b = 0.
//   - DRAIN: 2 cycles, so the last two results are checked.
//   - DONE: done=1, busy=0. On start, clear err_count/fail_vec/done and re-enter DRIVE.
//   Start qualification:
//   - In DRIVE/DRAIN, start is ignored.
//   - A start held high in DONE restarts every completed run.
//   Check latency:
//   - Pattern driven at edge t; gate captures it at t+1; dut_y is checked at edge t+2.
//   - Expected value and pattern index go through a 2-deep valid pipeline.
//   - The check fires only when the stage-2 valid bit is set.
//   Mismatch rule:
//   - Mismatch means dut_y != exp. On mismatch: err_count += 1 (saturating) and set fail_vec[idx].
//   Run timing:
//   - busy is high for 4*NUM_PASSES+2 cycles.
//   - done is set at the same edge as the final check, so it includes that result.
//   Idle drive:
//   - dut_a/dut_b are 0 in IDLE, DRAIN and DONE.
//   Counter width:
//   - The pass counter is clog2(NUM_PASSES)+1 bits.
//   - The pattern index is 2 bits and wraps 3 -> 0.
//
// STRUCTURE
//   Shared package (and_gate_pkg):
//   - FSM state enum {IDLE, DRIVE, DRAIN, DONE}.
//   - PAT_W=2, NUM_PAT=4, CHECK_LAT=2.
//   Sub-module sat_counter #(W):
//   - Saturating increment with synchronous clear, async reset.
//   - Used for err_count.
//   Kept in this block:
//   - FSM, pattern/pass counters, 2-stage expected-value pipeline and fail_vec logic.
//
// TESTING (NUM_PASSES=4, ERR_W=8 unless noted)
//   1. Good and_gate attached, start pulse
//      -> busy high 18 cycles, done=1, pass=1, err_count=0, fail_vec=4'b0000.
//   2. dut_y tied 0 -> err_count=4, fail_vec=4'b1000, pass=0.
//   3. dut_y tied 1 -> err_count=12, fail_vec=4'b0111, pass=0.
//   4. ERR_W=2, inverting DUT model -> err_count saturates at 3, fail_vec=4'b1111.
//   5. reset asserted 7 cycles into the run -> all outputs 0 immediately.
//      A later start then reproduces test 1.
//   6. start re-pulsed during busy -> ignored, run length still 18.
//      start in DONE -> done=0 next cycle, counters cleared, new run.

Source files
------------

// File: rtl/and_gate_pkg.sv
// Shared types and constants for the and_gate built-in self-test.
package and_gate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_W     = 2;
  localparam int NUM_PAT   = 4;
  localparam int CHECK_LAT = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/and_gate_bist.sv
// Exhaustive pattern driver and result checker for the registered and_gate cell.
// Results come back two edges after the drive, so expectations ride a valid pipeline.
module and_gate_bist
  import and_gate_pkg::*;
#(
  parameter int NUM_PASSES = 4,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       fail_vec,
  output state_t           fsm_state
);

  localparam int PASS_W = $clog2(NUM_PASSES) + 1;

  // Handshake: start is a level; it is accepted on any rising edge where the
  // FSM is in IDLE or DONE, and has no effect in DRIVE or DRAIN.
  state_t              state;
  logic [PAT_W-1:0]    pat;
  logic [PASS_W-1:0]   pass_cnt;
  logic                drain_cnt;
  logic                start_ok;
  logic                last_pat;

  logic [CHECK_LAT-1:0] vld_pipe;
  logic [CHECK_LAT-1:0] exp_pipe;
  logic [PAT_W-1:0]     idx_pipe [CHECK_LAT];
  logic                 mismatch;
  logic [PAT_W-1:0]     chk_idx;

  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign last_pat  = (pat == PAT_W'(NUM_PAT - 1)) && (pass_cnt == PASS_W'(NUM_PASSES - 1));
  assign mismatch  = vld_pipe[CHECK_LAT-1] && (dut_y != exp_pipe[CHECK_LAT-1]);
  assign chk_idx   = idx_pipe[CHECK_LAT-1];
  assign pass      = done && (err_count == '0);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat       <= '0;
      pass_cnt  <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          dut_a <= 1'b0;
          dut_b <= 1'b0;
          if (start_ok) begin
            state    <= DRIVE;
            busy     <= 1'b1;
            done     <= 1'b0;
            pat      <= '0;
            pass_cnt <= '0;
          end
        end
        DRIVE: begin
          dut_a <= pat[1];
          dut_b <= pat[0];
          pat   <= pat + 1'b1;
          if (pat == PAT_W'(NUM_PAT - 1)) pass_cnt <= pass_cnt + 1'b1;
          if (last_pat) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end
        end
        DRAIN: begin
          dut_a     <= 1'b0;
          dut_b     <= 1'b0;
          drain_cnt <= 1'b1;
          // Second drain edge is also the edge of the final check.
          if (drain_cnt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0 is loaded on the same edge the pattern is driven onto dut_a/dut_b.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
      for (int i = 0; i < CHECK_LAT; i++) idx_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= (state == DRIVE);
      exp_pipe[0] <= &pat;
      idx_pipe[0] <= pat;
      for (int i = 1; i < CHECK_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fail_vec <= '0;
    end else if (start_ok) begin
      fail_vec <= '0;
    end else if (mismatch) begin
      fail_vec[chk_idx] <= 1'b1;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (mismatch),
    .count (err_count)
  );

endmodule

// File: tb/tb_and_gate_bist.sv
// Bench for and_gate_bist: gate models driven by a 4-entry truth table, full and
// 2-bit saturating error counters side by side.
module tb_and_gate_bist;
  import and_gate_pkg::*;

  localparam int NUM_PASSES = 4;
  localparam int ERR_W      = 8;
  localparam int SAT_W      = 2;
  localparam int RUN_CYC    = 4 * NUM_PASSES + 2;
  localparam logic [3:0] GOOD_LUT = 4'b1000;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] lut = GOOD_LUT;

  logic             a0, b0, y0, busy0, done0, pass0;
  logic [ERR_W-1:0] err0;
  logic [3:0]       fail0;
  state_t           st0;

  logic             a1, b1, y1, busy1, done1, pass1;
  logic [SAT_W-1:0] err1;
  logic [3:0]       fail1;
  state_t           st1;

  and_gate_bist #(.NUM_PASSES(NUM_PASSES), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .dut_a(a0), .dut_b(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0),
    .fsm_state(st0)
  );

  and_gate_bist #(.NUM_PASSES(NUM_PASSES), .ERR_W(SAT_W)) u_dut_sat (
    .clk(clk), .reset(reset), .start(start), .dut_a(a1), .dut_b(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1),
    .fsm_state(st1)
  );

  // Registered gate models: y follows lut[{a,b}] one edge after the inputs.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      y0 <= 1'b0;
      y1 <= 1'b0;
    end else begin
      y0 <= lut[{a0, b0}];
      y1 <= lut[{a1, b1}];
    end
  end

  // scoreboard
  logic [1:0] exp_q[$];
  int n_asserts = 0;
  int n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run(input logic [3:0] l, input bit poke_start);
    logic [3:0] mask;
    int         n_err;
    int         n_busy;
    logic [1:0] e;
    lut = l;
    exp_q.delete();
    exp_q.push_back(2'd0);
    for (int k = 0; k < 4 * NUM_PASSES; k++) exp_q.push_back(2'(k % 4));
    exp_q.push_back(2'd0);

    // Reference: each pattern p is seen NUM_PASSES times and is wrong
    // whenever the gate's answer differs from a&b.
    mask = '0;
    for (int p = 0; p < 4; p++) mask[p] = (l[p] != (p == 3));
    n_err = NUM_PASSES * $countones(mask);

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_ack", {busy0, done0, pass0, err0, fail0, err1, fail1}, {1'b1, 1'b0, 1'b0, 18'd0});

    n_busy = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (!busy0) break;
      n_busy++;
      start = poke_start && (c == 5);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
      chk("drive_ab", {a0, b0}, e);
    end
    start = 1'b0;
    chk("busy_len", n_busy, RUN_CYC);
    chk("q_empty", exp_q.size(), 0);
    chk("done", done0, 1'b1);
    chk("pass", pass0, (mask == 4'd0));
    chk("err_count", err0, n_err);
    chk("fail_vec", fail0, mask);
    chk("sat_done", {done1, pass1}, {1'b1, (mask == 4'd0)});
    chk("sat_err", err1, (n_err > 3) ? 3 : n_err);
    chk("sat_fail", fail1, mask);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("reset_main", {a0, b0, busy0, done0, pass0, err0, fail0}, 0);
    chk("reset_sat", {a1, b1, busy1, done1, pass1, err1, fail1}, 0);

    run(GOOD_LUT, 1'b0);   // good gate
    run(4'b0000, 1'b0);    // y stuck at 0
    run(4'b1111, 1'b0);    // y stuck at 1
    run(4'b0111, 1'b0);    // inverting gate

    // Reset seven cycles into a run clears everything at once.
    lut = GOOD_LUT;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrun_reset", {a0, b0, busy0, done0, pass0, err0, fail0}, 0);
    chk("midrun_reset_sat", {a1, b1, busy1, done1, pass1, err1, fail1}, 0);
    @(negedge clk);
    reset = 1'b0;
    run(GOOD_LUT, 1'b0);

    run(4'b0111, 1'b0);
    run(GOOD_LUT, 1'b1);   // start during busy is ignored

    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run(4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
